mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the core and the byte-wide synchronous RAM. It accepts word, halfword and byte requests from the load/store queue, and 4-byte instruction fetch requests from the fetcher. It arbitrates between the two, sequences one RAM byte per cycle, and returns zero-extended little-endian data with a one-cycle ready pulse. Sign extension belongs to the load/store queue.

## Interface
Parameters:
- none; widths come from `constant.v` (`DATA_WIDTH` = 32).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- ena  in  1  global enable; low freezes all state, holds outputs, forces out_ram_wr=0
- in_rollback  in  1  misbranch flush
- in_ls_ena  in  1  one-cycle LS request pulse
- in_ls_iswrite  in  1  1=store, 0=load
- in_ls_addr  in  32  byte address, stable until ready
- in_ls_data  in  32  store data; low bytes used
- in_ls_size  in  3  1, 2 or 4 bytes
- out_ls_ready  out  1  one-cycle done pulse
- out_ls_data  out  32  load result, zero-extended
- in_if_ena  in  1  one-cycle fetch pulse
- in_if_addr  in  32  fetch address
- out_if_ready  out  1  one-cycle done pulse
- out_if_inst  out  32  fetched word
- in_ram_data  in  8  RAM read byte
- out_ram_addr  out  32  RAM byte address
- out_ram_data  out  8  RAM write byte
- out_ram_wr  out  1  RAM write strobe

## Operation
- Reset: state IDLE; all outputs 0; both pending flags cleared; byte counter 0.
- Request latching: in_ls_ena / in_if_ena set a pending flag and capture the request fields. A pulse is never lost, even when the block is busy.
- States: IDLE, LS_READ, LS_WRITE, IF_READ.
- IDLE arbitration:
  - LS pending wins over IF pending.
  - The winner's pending flag clears and the block moves to LS_READ/LS_WRITE or IF_READ.
  - A request pulse arriving in IDLE can start on that same edge.
- READ of n bytes:
  - Drive out_ram_addr = base+k for k=0..n-1 on successive cycles.
  - Capture in_ram_data into byte lane k one cycle after each address.
  - Upper lanes are 0.
- WRITE of n bytes: drive addr base+k, out_ram_data = data[8k+7:8k], out_ram_wr=1 for k=0..n-1.
- Completion:
  - Pulse the matching ready for exactly one cycle with final data, then return to IDLE.
  - out_*_data holds its value until the next completion.
- Sizes other than 1 or 2 are treated as 4.
- Address arithmetic is 32-bit with wrap; no alignment check.
- Rollback:
  - Aborts IF_READ and LS_READ in flight: return to IDLE, no ready pulse.
  - Clears both pending flags, except a pending LS write.
  - LS_WRITE in flight always completes and pulses ready, because stores are committed.
  - Rollback in the same cycle as a new pulse: the pulse is dropped unless it is an LS write.
- Idle outputs: out_ram_wr=0, out_ram_addr=0.

## Timing
- E0 is the edge that starts a request.
- Read:
  - Address k is registered at edge E_k and sampled by the RAM at E_{k+1}.
  - Byte k is captured at E_{k+2}.
  - Ready is high in the cycle after E_{n+1}.
  - Word load or fetch: ready 5 edges after start. Byte load: 2 edges.
- Write: byte k is written at E_{k+1}; ready is high in the cycle after E_n (word: 4 edges).
- Back-to-back: a request pending at completion starts on the edge after the ready edge. There is one IDLE cycle between transactions.
- ena low: counters and state hold. A RAM read interrupted by ena must re-issue the outstanding address before resuming capture.
- rst overrides rollback and ena, including mid-transaction.

## Structure
- State encodings and the size codes (1/2/4) go into `constant.v` alongside `DATA_WIDTH`.
- Single module.
- A small byte-lane assembler (`mem_byte_lane`) is the only natural sub-module. It is optional and inlining it is acceptable.

## Test plan
- Word load: RAM[0x100..0x103]=11 22 33 44; LS pulse read size 4 at 0x100 → out_ls_ready 5 edges later, out_ls_data=0x44332211.
- Byte store then load:
  - Store size 1, data 0xAABBCCDD, at 0x200 → one RAM write of 0xDD, ready 1 edge later.
  - Load size 1 at 0x200 → 0x000000DD.
- Simultaneous IF and LS pulses at 0x0 (inst 0x00000013) and 0x100 → LS completes first; IF ready arrives after the IDLE gap with 0x00000013.
- Rollback mid fetch: IF at 0x0, rollback at edge 2 → no out_if_ready, IDLE next cycle, RAM untouched.
- Rollback during a word store: 0x12345678 at 0x300 → all 4 bytes written, out_ls_ready pulses, memory reads back 0x12345678.
- rst asserted mid load → all outputs 0 next cycle, no ready pulse; the next request is served normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, size codes and FSM state encoding for the byte-wide RAM controller.
package mem_ctrl_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [2:0] SZ_BYTE = 3'd1;
   localparam logic [2:0] SZ_HALF = 3'd2;
   localparam logic [2:0] SZ_WORD = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LS_READ  = 2'd1,
      ST_LS_WRITE = 2'd2,
      ST_IF_READ  = 2'd3
   } state_t;

   // Any size code other than byte or halfword moves a full word.
   function automatic logic [2:0] size_bytes(input logic [2:0] size);
      case (size)
         SZ_BYTE: return SZ_BYTE;
         SZ_HALF: return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates LS (priority) and IF requests onto a byte-wide sync RAM, one byte per cycle.
// Ready pulses n+1 edges after start for reads, n for writes; request pulses are latched while busy.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  in_rollback,
   input  logic                  in_ls_ena,
   input  logic                  in_ls_iswrite,
   input  logic [DATA_WIDTH-1:0] in_ls_addr,
   input  logic [DATA_WIDTH-1:0] in_ls_data,
   input  logic [2:0]            in_ls_size,
   output logic                  out_ls_ready,
   output logic [DATA_WIDTH-1:0] out_ls_data,
   input  logic                  in_if_ena,
   input  logic [DATA_WIDTH-1:0] in_if_addr,
   output logic                  out_if_ready,
   output logic [DATA_WIDTH-1:0] out_if_inst,
   input  logic [7:0]            in_ram_data,
   output logic [DATA_WIDTH-1:0] out_ram_addr,
   output logic [7:0]            out_ram_data,
   output logic                  out_ram_wr
);

   state_t                r_state, w_state;
   logic                  r_ls_pend, w_ls_pend;
   logic                  r_ls_wr, w_ls_wr;
   logic [DATA_WIDTH-1:0] r_ls_addr, w_ls_addr;
   logic [DATA_WIDTH-1:0] r_ls_wdat, w_ls_wdat;
   logic [2:0]            r_ls_size, w_ls_size;
   logic                  r_if_pend, w_if_pend;
   logic [DATA_WIDTH-1:0] r_if_addr, w_if_addr;

   logic [DATA_WIDTH-1:0] r_base, w_base;
   logic [DATA_WIDTH-1:0] r_wdat, w_wdat;
   logic [2:0]            r_n, w_n;
   logic [2:0]            r_cnt, w_cnt;
   logic                  r_skip, w_skip;
   logic                  r_stall;
   logic [DATA_WIDTH-1:0] r_lanes, w_lanes;

   logic [DATA_WIDTH-1:0] r_ram_addr, w_ram_addr;
   logic [7:0]            r_ram_dat, w_ram_dat;
   logic                  r_ram_wr, w_ram_wr;
   logic                  r_ls_ready, w_ls_ready;
   logic [DATA_WIDTH-1:0] r_ls_rdat, w_ls_rdat;
   logic                  r_if_ready, w_if_ready;
   logic [DATA_WIDTH-1:0] r_if_inst, w_if_inst;

   logic                  w_ls_take, w_ls_any, w_ls_wr_s, w_if_any;
   logic [DATA_WIDTH-1:0] w_ls_addr_s, w_ls_dat_s, w_if_addr_s;
   logic [2:0]            w_ls_size_s, w_cnt_inc, w_cnt_dec;

   always_comb begin
      // A rollback drops everything except a store, which is already committed.
      w_ls_take   = in_ls_ena && (!in_rollback || in_ls_iswrite);
      w_ls_any    = w_ls_take || (r_ls_pend && (!in_rollback || r_ls_wr));
      w_ls_wr_s   = w_ls_take ? in_ls_iswrite : r_ls_wr;
      w_ls_addr_s = w_ls_take ? in_ls_addr    : r_ls_addr;
      w_ls_dat_s  = w_ls_take ? in_ls_data    : r_ls_wdat;
      w_ls_size_s = w_ls_take ? in_ls_size    : r_ls_size;
      w_if_any    = (in_if_ena || r_if_pend) && !in_rollback;
      w_if_addr_s = in_if_ena ? in_if_addr : r_if_addr;
      w_cnt_inc   = r_cnt + 3'd1;
      w_cnt_dec   = r_cnt - 3'd1;

      w_state    = r_state;
      w_ls_pend  = w_ls_any;
      w_ls_wr    = w_ls_wr_s;
      w_ls_addr  = w_ls_addr_s;
      w_ls_wdat  = w_ls_dat_s;
      w_ls_size  = w_ls_size_s;
      w_if_pend  = w_if_any;
      w_if_addr  = w_if_addr_s;
      w_base     = r_base;
      w_wdat     = r_wdat;
      w_n        = r_n;
      w_cnt      = r_cnt;
      w_skip     = r_skip;
      w_lanes    = r_lanes;
      w_ram_addr = r_ram_addr;
      w_ram_dat  = r_ram_dat;
      w_ram_wr   = r_ram_wr;
      w_ls_ready = 1'b0;
      w_ls_rdat  = r_ls_rdat;
      w_if_ready = 1'b0;
      w_if_inst  = r_if_inst;

      case (r_state)
         ST_IDLE: begin
            w_ram_addr = '0;
            w_ram_wr   = 1'b0;
            w_cnt      = 3'd0;
            w_skip     = 1'b0;
            if (w_ls_any) begin
               w_ls_pend  = 1'b0;
               w_base     = w_ls_addr_s;
               w_wdat     = w_ls_dat_s;
               w_n        = size_bytes(w_ls_size_s);
               w_lanes    = '0;
               w_ram_addr = w_ls_addr_s;
               if (w_ls_wr_s) begin
                  w_state   = ST_LS_WRITE;
                  w_ram_wr  = 1'b1;
                  w_ram_dat = w_ls_dat_s[7:0];
               end else begin
                  w_state   = ST_LS_READ;
               end
            end else if (w_if_any) begin
               w_if_pend  = 1'b0;
               w_base     = w_if_addr_s;
               w_n        = SZ_WORD;
               w_lanes    = '0;
               w_ram_addr = w_if_addr_s;
               w_state    = ST_IF_READ;
            end
         end

         ST_LS_WRITE: begin
            if (w_cnt_inc < r_n) begin
               w_cnt      = w_cnt_inc;
               w_ram_addr = r_base + {29'd0, w_cnt_inc};
               w_ram_dat  = r_wdat[{w_cnt_inc[1:0], 3'b000} +: 8];
            end else begin
               w_state    = ST_IDLE;
               w_ram_wr   = 1'b0;
               w_ram_addr = '0;
               w_ram_dat  = '0;
               w_ls_ready = 1'b1;
            end
         end

         ST_LS_READ, ST_IF_READ: begin
            if (in_rollback) begin
               w_state    = ST_IDLE;
               w_ram_addr = '0;
               w_skip     = 1'b0;
            end else if (r_stall) begin
               // RAM kept sampling the newest address while frozen; re-issue the one still owed.
               w_cnt      = w_cnt_dec;
               w_skip     = 1'b1;
               w_ram_addr = r_base + {29'd0, w_cnt_dec};
            end else begin
               if (!r_skip && (r_cnt != 3'd0))
                  w_lanes[{w_cnt_dec[1:0], 3'b000} +: 8] = in_ram_data;
               if (r_cnt == r_n) begin
                  w_state    = ST_IDLE;
                  w_ram_addr = '0;
                  if (r_state == ST_LS_READ) begin
                     w_ls_ready = 1'b1;
                     w_ls_rdat  = w_lanes;
                  end else begin
                     w_if_ready = 1'b1;
                     w_if_inst  = w_lanes;
                  end
               end else begin
                  w_cnt  = w_cnt_inc;
                  w_skip = 1'b0;
                  if (w_cnt_inc < r_n)
                     w_ram_addr = r_base + {29'd0, w_cnt_inc};
               end
            end
         end

         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ls_pend  <= 1'b0;
         r_ls_wr    <= 1'b0;
         r_ls_addr  <= '0;
         r_ls_wdat  <= '0;
         r_ls_size  <= '0;
         r_if_pend  <= 1'b0;
         r_if_addr  <= '0;
         r_base     <= '0;
         r_wdat     <= '0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_skip     <= 1'b0;
         r_stall    <= 1'b0;
         r_lanes    <= '0;
         r_ram_addr <= '0;
         r_ram_dat  <= '0;
         r_ram_wr   <= 1'b0;
         r_ls_ready <= 1'b0;
         r_ls_rdat  <= '0;
         r_if_ready <= 1'b0;
         r_if_inst  <= '0;
      end else if (!ena) begin
         if ((r_state == ST_LS_READ || r_state == ST_IF_READ) && !r_skip && (r_cnt != 3'd0))
            r_stall <= 1'b1;
      end else begin
         r_state    <= w_state;
         r_ls_pend  <= w_ls_pend;
         r_ls_wr    <= w_ls_wr;
         r_ls_addr  <= w_ls_addr;
         r_ls_wdat  <= w_ls_wdat;
         r_ls_size  <= w_ls_size;
         r_if_pend  <= w_if_pend;
         r_if_addr  <= w_if_addr;
         r_base     <= w_base;
         r_wdat     <= w_wdat;
         r_n        <= w_n;
         r_cnt      <= w_cnt;
         r_skip     <= w_skip;
         r_stall    <= 1'b0;
         r_lanes    <= w_lanes;
         r_ram_addr <= w_ram_addr;
         r_ram_dat  <= w_ram_dat;
         r_ram_wr   <= w_ram_wr;
         r_ls_ready <= w_ls_ready;
         r_ls_rdat  <= w_ls_rdat;
         r_if_ready <= w_if_ready;
         r_if_inst  <= w_if_inst;
      end
   end

   assign out_ls_ready = r_ls_ready;
   assign out_ls_data  = r_ls_rdat;
   assign out_if_ready = r_if_ready;
   assign out_if_inst  = r_if_inst;
   assign out_ram_addr = r_ram_addr;
   assign out_ram_data = r_ram_dat;
   assign out_ram_wr   = r_ram_wr & ena;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model plus a flat-array reference memory for expected data.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, ena, in_rollback;
   logic        in_ls_ena, in_ls_iswrite;
   logic [31:0] in_ls_addr, in_ls_data;
   logic [2:0]  in_ls_size;
   logic        out_ls_ready;
   logic [31:0] out_ls_data;
   logic        in_if_ena;
   logic [31:0] in_if_addr;
   logic        out_if_ready;
   logic [31:0] out_if_inst;
   logic [7:0]  in_ram_data;
   logic [31:0] out_ram_addr;
   logic [7:0]  out_ram_data;
   logic        out_ram_wr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mem     [0:4095];
   logic [7:0]  ref_mem [0:4095];
   int          wr_count = 0;
   logic        fill_vld, poke_vld;
   logic [11:0] poke_a;
   logic [7:0]  poke_d;
   logic [2:0]  sz_tab [0:5] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd7};

   mem_ctrl dut (
      .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback),
      .in_ls_ena(in_ls_ena), .in_ls_iswrite(in_ls_iswrite), .in_ls_addr(in_ls_addr),
      .in_ls_data(in_ls_data), .in_ls_size(in_ls_size), .out_ls_ready(out_ls_ready),
      .out_ls_data(out_ls_data), .in_if_ena(in_if_ena), .in_if_addr(in_if_addr),
      .out_if_ready(out_if_ready), .out_if_inst(out_if_inst), .in_ram_data(in_ram_data),
      .out_ram_addr(out_ram_addr), .out_ram_data(out_ram_data), .out_ram_wr(out_ram_wr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A;
   endfunction

   // Synchronous byte RAM: one-cycle read latency, write on the strobe.
   always @(posedge clk) begin
      if (fill_vld) begin
         for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
      end else if (poke_vld) begin
         mem[poke_a] <= poke_d;
      end else if (out_ram_wr) begin
         mem[out_ram_addr[11:0]] <= out_ram_data;
      end
      if (out_ram_wr) wr_count <= wr_count + 1;
      in_ram_data <= mem[out_ram_addr[11:0]];
   end

   function automatic int nbytes(input logic [2:0] s);
      return (s == 3'd1) ? 1 : (s == 3'd2) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
      logic [31:0] v;
      logic [31:0] ak;
      v = '0;
      for (int k = 0; k < nbytes(s); k++) begin
         ak = a + k;
         v[8*k +: 8] = ref_mem[ak[11:0]];
      end
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
      logic [31:0] ak;
      for (int k = 0; k < nbytes(s); k++) begin
         ak = a + k;
         ref_mem[ak[11:0]] = d[8*k +: 8];
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic poke(input logic [11:0] a, input logic [7:0] d);
      ref_mem[a] = d;
      poke_a = a; poke_d = d; poke_vld = 1'b1;
      tick();
      poke_vld = 1'b0;
   endtask

   // Pulse one LS request, return edges-to-ready (-1 on timeout) and the ready state one cycle later.
   task automatic ls_xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] s, output logic [31:0] rd, output int lat,
                          output logic rdy2);
      in_ls_ena = 1'b1; in_ls_iswrite = wr; in_ls_addr = a; in_ls_data = d; in_ls_size = s;
      tick();
      in_ls_ena = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (out_ls_ready) begin lat = i; break; end
      end
      rd = out_ls_data;
      tick();
      rdy2 = out_ls_ready;
   endtask

   task automatic if_xact(input logic [31:0] a, output logic [31:0] rd, output int lat);
      in_if_ena = 1'b1; in_if_addr = a;
      tick();
      in_if_ena = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (out_if_ready) begin lat = i; break; end
      end
      rd = out_if_inst;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({out_ls_ready, out_if_ready, out_ram_wr} !== 3'b000) begin
         n_bad++; $display("FAIL reset_strobes got %b want 000", {out_ls_ready, out_if_ready, out_ram_wr});
      end
      n_cmp++;
      if (out_ls_data !== 32'h0 || out_if_inst !== 32'h0) begin
         n_bad++; $display("FAIL reset_data got %h/%h want 0/0", out_ls_data, out_if_inst);
      end
      n_cmp++;
      if (out_ram_addr !== 32'h0 || out_ram_data !== 8'h0) begin
         n_bad++; $display("FAIL reset_ram got %h/%h want 0/0", out_ram_addr, out_ram_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_word_load();
      logic [31:0] rd; int lat; logic rdy2;
      poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
      ls_xact(1'b0, 32'h100, 32'h0, 3'd4, rd, lat, rdy2);
      n_cmp++;
      if (lat !== 5) begin n_bad++; $display("FAIL word_load_latency got %0d want 5", lat); end
      n_cmp++;
      if (rd !== 32'h44332211) begin n_bad++; $display("FAIL word_load_data got %h want 44332211", rd); end
      n_cmp++;
      if (rdy2 !== 1'b0) begin n_bad++; $display("FAIL ready_pulse_width got %b want 0", rdy2); end
      n_cmp++;
      if (out_ls_data !== 32'h44332211) begin
         n_bad++; $display("FAIL ls_data_hold got %h want 44332211", out_ls_data);
      end
   endtask

   task automatic test_byte_store_load();
      logic [31:0] rd; int lat; logic rdy2; int wc0;
      wc0 = wr_count;
      ls_xact(1'b1, 32'h200, 32'hAABBCCDD, 3'd1, rd, lat, rdy2);
      ref_store(32'h200, 32'hAABBCCDD, 3'd1);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL byte_store_latency got %0d want 1", lat); end
      n_cmp++;
      if (wr_count - wc0 !== 1) begin n_bad++; $display("FAIL byte_store_writes got %0d want 1", wr_count - wc0); end
      n_cmp++;
      if (mem[12'h200] !== 8'hDD || mem[12'h201] !== ref_mem[12'h201]) begin
         n_bad++; $display("FAIL byte_store_mem got %h %h want dd %h", mem[12'h200], mem[12'h201], ref_mem[12'h201]);
      end
      ls_xact(1'b0, 32'h200, 32'h0, 3'd1, rd, lat, rdy2);
      n_cmp++;
      if (lat !== 2 || rd !== 32'h000000DD) begin
         n_bad++; $display("FAIL byte_load got lat %0d data %h want lat 2 data 000000dd", lat, rd);
      end
      ls_xact(1'b0, 32'h200, 32'h0, 3'd2, rd, lat, rdy2);
      n_cmp++;
      if (lat !== 3 || rd !== ref_load(32'h200, 3'd2)) begin
         n_bad++; $display("FAIL half_load got lat %0d data %h want lat 3 data %h", lat, rd, ref_load(32'h200, 3'd2));
      end
   endtask

   task automatic test_simultaneous();
      int ls_lat, if_lat; logic [31:0] ls_d, if_d;
      poke(12'h000, 8'h13); poke(12'h001, 8'h00); poke(12'h002, 8'h00); poke(12'h003, 8'h00);
      in_if_ena = 1'b1; in_if_addr = 32'h0;
      in_ls_ena = 1'b1; in_ls_iswrite = 1'b0; in_ls_addr = 32'h100; in_ls_size = 3'd4;
      tick();
      in_if_ena = 1'b0; in_ls_ena = 1'b0;
      ls_lat = -1; if_lat = -1; ls_d = '0; if_d = '0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (out_ls_ready && ls_lat < 0) begin ls_lat = i; ls_d = out_ls_data; end
         if (out_if_ready && if_lat < 0) begin if_lat = i; if_d = out_if_inst; end
      end
      n_cmp++;
      if (ls_lat !== 5 || ls_d !== ref_load(32'h100, 3'd4)) begin
         n_bad++; $display("FAIL simul_ls got lat %0d data %h want lat 5 data %h", ls_lat, ls_d, ref_load(32'h100, 3'd4));
      end
      n_cmp++;
      if (if_lat !== 11 || if_d !== 32'h00000013) begin
         n_bad++; $display("FAIL simul_if got lat %0d data %h want lat 11 data 00000013", if_lat, if_d);
      end
   endtask

   task automatic test_back_to_back();
      int ls_lat, if_lat;
      in_if_ena = 1'b1; in_if_addr = 32'h0;
      tick();
      in_if_ena = 1'b0;
      ls_lat = -1; if_lat = -1;
      for (int i = 1; i <= 30; i++) begin
         if (i == 2) begin
            in_ls_ena = 1'b1; in_ls_iswrite = 1'b0; in_ls_addr = 32'h100; in_ls_size = 3'd4;
         end
         tick();
         in_ls_ena = 1'b0;
         if (out_ls_ready && ls_lat < 0) ls_lat = i;
         if (out_if_ready && if_lat < 0) if_lat = i;
      end
      n_cmp++;
      if (if_lat !== 5 || ls_lat !== 11) begin
         n_bad++; $display("FAIL back_to_back got if %0d ls %0d want if 5 ls 11", if_lat, ls_lat);
      end
   endtask

   task automatic test_rollback_fetch();
      logic [31:0] fa [0:1] = '{32'h0, 32'h40};
      logic [31:0] rd; int lat, wc0; logic seen; logic [31:0] addr_after;
      for (int t = 0; t < 2; t++) begin
         wc0 = wr_count;
         in_if_ena = 1'b1; in_if_addr = fa[t];
         tick();
         in_if_ena = 1'b0;
         tick();
         in_rollback = 1'b1;
         tick();
         in_rollback = 1'b0;
         addr_after = out_ram_addr;
         seen = out_if_ready;
         repeat (10) begin tick(); if (out_if_ready) seen = 1'b1; end
         n_cmp++;
         if (seen !== 1'b0) begin n_bad++; $display("FAIL rollback_fetch_ready got %b want 0", seen); end
         n_cmp++;
         if (addr_after !== 32'h0) begin n_bad++; $display("FAIL rollback_fetch_idle got %h want 0", addr_after); end
         n_cmp++;
         if (wr_count !== wc0) begin n_bad++; $display("FAIL rollback_fetch_ram got %0d want %0d", wr_count, wc0); end
      end
      if_xact(32'h0, rd, lat);
      n_cmp++;
      if (lat !== 5 || rd !== 32'h00000013) begin
         n_bad++; $display("FAIL fetch_after_rollback got lat %0d data %h want 5 00000013", lat, rd);
      end
   endtask

   task automatic test_rollback_store();
      logic [31:0] rd; int lat, wc0; logic rdy2;
      wc0 = wr_count;
      in_ls_ena = 1'b1; in_ls_iswrite = 1'b1; in_ls_addr = 32'h300; in_ls_data = 32'h12345678; in_ls_size = 3'd4;
      tick();
      in_ls_ena = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         in_rollback = (i == 1);
         tick();
         in_rollback = 1'b0;
         if (out_ls_ready && lat < 0) lat = i;
      end
      ref_store(32'h300, 32'h12345678, 3'd4);
      n_cmp++;
      if (lat !== 4) begin n_bad++; $display("FAIL rollback_store_ready got %0d want 4", lat); end
      n_cmp++;
      if (wr_count - wc0 !== 4) begin n_bad++; $display("FAIL rollback_store_writes got %0d want 4", wr_count - wc0); end
      ls_xact(1'b0, 32'h300, 32'h0, 3'd4, rd, lat, rdy2);
      n_cmp++;
      if (rd !== 32'h12345678) begin n_bad++; $display("FAIL rollback_store_readback got %h want 12345678", rd); end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] rd; int lat; logic rdy2, seen;
      in_ls_ena = 1'b1; in_ls_iswrite = 1'b0; in_ls_addr = 32'h100; in_ls_size = 3'd4;
      tick();
      in_ls_ena = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({out_ls_ready, out_if_ready, out_ram_wr} !== 3'b000 || out_ls_data !== 32'h0 ||
          out_if_inst !== 32'h0 || out_ram_addr !== 32'h0 || out_ram_data !== 8'h0) begin
         n_bad++; $display("FAIL mid_reset_outputs got %h %h %h want all zero", out_ls_data, out_if_inst, out_ram_addr);
      end
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin tick(); if (out_ls_ready) seen = 1'b1; end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready got %b want 0", seen); end
      ls_xact(1'b0, 32'h100, 32'h0, 3'd4, rd, lat, rdy2);
      n_cmp++;
      if (lat !== 5 || rd !== ref_load(32'h100, 3'd4)) begin
         n_bad++; $display("FAIL load_after_reset got lat %0d data %h want 5 %h", lat, rd, ref_load(32'h100, 3'd4));
      end
   endtask

   task automatic test_ena_stall();
      logic [31:0] rd, wd; int cyc, wc0; logic got, wr_seen;
      for (int s = 0; s <= 4; s++) begin
         in_ls_ena = 1'b1; in_ls_iswrite = 1'b0; in_ls_addr = 32'h400 + 32'(s * 8); in_ls_size = 3'd4;
         tick();
         in_ls_ena = 1'b0;
         got = 1'b0; cyc = 0; rd = '0;
         if (s == 0) begin ena = 1'b0; tick(); tick(); ena = 1'b1; end
         while (!got && cyc < 40) begin
            tick(); cyc++;
            if (out_ls_ready) begin got = 1'b1; rd = out_ls_data; end
            else if (cyc == s) begin ena = 1'b0; tick(); tick(); tick(); ena = 1'b1; end
         end
         n_cmp++;
         if (!got || rd !== ref_load(32'h400 + 32'(s * 8), 3'd4)) begin
            n_bad++; $display("FAIL ena_stall_load_%0d got %h want %h", s, rd, ref_load(32'h400 + 32'(s * 8), 3'd4));
         end
         tick();
      end
      wd = $urandom; wc0 = wr_count;
      in_ls_ena = 1'b1; in_ls_iswrite = 1'b1; in_ls_addr = 32'h500; in_ls_data = wd; in_ls_size = 3'd4;
      tick();
      in_ls_ena = 1'b0;
      tick();
      ena = 1'b0; wr_seen = 1'b0;
      repeat (3) begin tick(); if (out_ram_wr) wr_seen = 1'b1; end
      ena = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(); if (out_ls_ready) got = 1'b1; end
      ref_store(32'h500, wd, 3'd4);
      n_cmp++;
      if (wr_seen !== 1'b0) begin n_bad++; $display("FAIL ena_low_wr got %b want 0", wr_seen); end
      n_cmp++;
      if (!got || wr_count - wc0 !== 4) begin
         n_bad++; $display("FAIL ena_stall_store got ready %b writes %0d want 1 4", got, wr_count - wc0);
      end
      n_cmp++;
      if (ref_load(32'h500, 3'd4) !== {mem[12'h503], mem[12'h502], mem[12'h501], mem[12'h500]}) begin
         n_bad++; $display("FAIL ena_stall_store_mem got %h%h%h%h want %h", mem[12'h503], mem[12'h502],
                           mem[12'h501], mem[12'h500], ref_load(32'h500, 3'd4));
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d, rd, exp; logic [2:0] s; int sel, lat, wc0; logic rdy2;
      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 2);
         a = {($urandom_range(0, 1) != 0) ? 20'hFFFFF : 20'h00000, 12'($urandom)};
         d = $urandom;
         s = sz_tab[$urandom_range(0, 5)];
         wc0 = wr_count;
         if (sel == 2) begin
            exp = ref_load(a, 3'd4);
            if_xact(a, rd, lat);
            n_cmp++;
            if (lat !== 5 || rd !== exp) begin
               n_bad++; $display("FAIL rand_fetch_%0d a=%h got lat %0d %h want 5 %h", t, a, lat, rd, exp);
            end
         end else if (sel == 1) begin
            ls_xact(1'b1, a, d, s, rd, lat, rdy2);
            ref_store(a, d, s);
            n_cmp++;
            if (lat !== nbytes(s) || wr_count - wc0 !== nbytes(s)) begin
               n_bad++; $display("FAIL rand_store_%0d size %0d got lat %0d writes %0d want %0d", t, s, lat,
                                 wr_count - wc0, nbytes(s));
            end
         end else begin
            exp = ref_load(a, s);
            ls_xact(1'b0, a, d, s, rd, lat, rdy2);
            n_cmp++;
            if (lat !== nbytes(s) + 1 || rd !== exp) begin
               n_bad++; $display("FAIL rand_load_%0d a=%h size %0d got lat %0d %h want %0d %h", t, a, s, lat,
                                 rd, nbytes(s) + 1, exp);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; in_rollback = 1'b0;
      in_ls_ena = 1'b0; in_ls_iswrite = 1'b0; in_ls_addr = '0; in_ls_data = '0; in_ls_size = '0;
      in_if_ena = 1'b0; in_if_addr = '0;
      poke_vld = 1'b0; poke_a = '0; poke_d = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = pat(12'(i));
      fill_vld = 1'b1;
      tick();
      fill_vld = 1'b0;
      test_reset();
      test_word_load();
      test_byte_store_load();
      test_simultaneous();
      test_back_to_back();
      test_rollback_fetch();
      test_rollback_store();
      test_reset_mid_load();
      test_ena_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
